uart_send_hex: RTL and testbench

Parametrised hex-dump line sender for the UART monitor, succeeding the fixed two-word dumper. On a start pulse it captures a line's worth of 32-bit words and an optional address, then streams one ASCII character per accepted cycle into the UART TX FIFO. A line is `[addr ": "] word0 " " word1 … wordN-1 CR LF`. The block sits between the monitor's memory-read path and the UART interface, and signals line completion back to monitor control.

---
 rtl/uart_send_hex_pkg.sv | 25 ++
 rtl/uart_send_hex_nibble.sv | 22 ++
 rtl/uart_send_hex.sv | 135 +++++++++++++
 tb/tb_uart_send_hex.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_send_hex_pkg.sv
// Shared constants for the hex-dump line sender: ASCII codes and FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_send_hex_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_LA    = 8'h61;
    localparam logic [7:0] ASCII_UA    = 8'h41;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_COLON = 3'd2,
        S_ASP   = 3'd3,
        S_DATA  = 3'd4,
        S_SEP   = 3'd5,
        S_CR    = 3'd6,
        S_LF    = 3'd7
    } state_t;

endpackage

// File: rtl/uart_send_hex_nibble.sv
// Nibble to ASCII hex digit encoder, letter case chosen by UPPER.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module hex_nibble_ascii
    import uart_send_hex_pkg::*;
#(
    parameter bit UPPER = 1'b0
) (
    input  logic [3:0] i_nib,
    output logic [7:0] o_char
);

    // Digits map onto '0'..'9', values 10..15 onto the selected letter range.
    always_comb begin
        if (i_nib < 4'd10) begin
            o_char = ASCII_ZERO + {4'd0, i_nib};
        end else begin
            o_char = (UPPER ? ASCII_UA : ASCII_LA) + {4'd0, i_nib} - 8'd10;
        end
    end

endmodule

// File: rtl/uart_send_hex.sv
// Hex-dump line sender: captures WORDS words (+ optional address) and streams ASCII.
// Latency: first character offered the cycle after start is sampled; 1 char/cycle.
// Backpressure: tx_fifo_full freezes state and send_char, send_en drops.
module uart_send_hex
    import uart_send_hex_pkg::*;
#(
    parameter int WORDS   = 2,
    parameter bit ADDR_EN = 1'b0,
    parameter bit UPPER   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [32*WORDS-1:0]   data,
    input  logic [31:0]           addr,
    input  logic                  crlf_in,
    input  logic                  tx_fifo_full,
    output logic [7:0]            send_char,
    output logic                  send_en,
    output logic                  busy,
    output logic                  line_done
);

    localparam int WIDX = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WIDX-1:0] LAST_WORD = WIDX'(WORDS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_nib;
    logic [WIDX-1:0]       r_word;
    logic [32*WORDS-1:0]   r_data;
    logic [31:0]           r_addr;

    logic                  w_adv;
    logic                  w_accept;
    logic [31:0]           w_word;
    logic [31:0]           w_src;
    logic [3:0]            w_nib;
    logic [7:0]            w_hex;

    assign busy      = (r_state != S_IDLE);
    assign send_en   = busy & ~tx_fifo_full;
    assign line_done = (r_state == S_LF) & ~tx_fifo_full;
    assign w_adv     = send_en;
    assign w_accept  = ~busy & start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: IDLE reacts to requests (start beats crlf_in), others move only on an accepted character.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = ADDR_EN ? S_ADDR : S_DATA;
                end else if (crlf_in) begin
                    w_state_nxt = S_CR;
                end
            end
            S_ADDR:  if (w_adv && (r_nib == 3'd0)) w_state_nxt = S_COLON;
            S_COLON: if (w_adv) w_state_nxt = S_ASP;
            S_ASP:   if (w_adv) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_adv && (r_nib == 3'd0)) begin
                    w_state_nxt = (r_word != LAST_WORD) ? S_SEP : S_CR;
                end
            end
            S_SEP:   if (w_adv) w_state_nxt = S_DATA;
            S_CR:    if (w_adv) w_state_nxt = S_LF;
            S_LF:    if (w_adv) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture on accepted start; nibble counter wraps 0->7 between address and each word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nib  <= 3'd0;
            r_word <= '0;
            r_data <= '0;
            r_addr <= '0;
        end else if (w_accept) begin
            r_data <= data;
            r_addr <= addr;
            r_nib  <= 3'd7;
            r_word <= '0;
        end else if (w_adv) begin
            case (r_state)
                S_ADDR, S_DATA: r_nib  <= r_nib - 3'd1;
                S_SEP:          r_word <= r_word + 1'b1;
                default:        ;
            endcase
        end
    end

    // Word select from the capture register by word index.
    always_comb begin
        w_word = r_data[31:0];
        for (int k = 1; k < WORDS; k++) begin
            if (r_word == WIDX'(k)) begin
                w_word = r_data[32*k +: 32];
            end
        end
    end

    assign w_src = (r_state == S_ADDR) ? r_addr : w_word;
    assign w_nib = w_src[{r_nib, 2'b00} +: 4];

    hex_nibble_ascii #(
        .UPPER (UPPER)
    ) u_hex (
        .i_nib  (w_nib),
        .o_char (w_hex)
    );

    // Character offered depends only on registered state, so it holds across stalls.
    always_comb begin
        send_char = ASCII_SPACE;
        case (r_state)
            S_ADDR, S_DATA: send_char = w_hex;
            S_COLON:        send_char = ASCII_COLON;
            S_CR:           send_char = ASCII_CR;
            S_LF:           send_char = ASCII_LF;
            default:        send_char = ASCII_SPACE;
        endcase
    end

endmodule

// File: tb/tb_uart_send_hex.sv
// Bench for uart_send_hex: three configurations, vector table, random lines, corner sequences.
// Latency: n/a.
// Backpressure: tx_fifo_full driven pseudo-randomly per vector.
module tb_uart_send_hex;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   sel = 2'd0;
    logic         start_d = 1'b0;
    logic         crlf_d = 1'b0;
    logic         full_d = 1'b0;
    logic [511:0] data_d = '0;
    logic [31:0]  addr_d = '0;

    logic [7:0] a_ch, b_ch, c_ch, o_ch;
    logic       a_en, b_en, c_en, o_en;
    logic       a_bsy, b_bsy, c_bsy, o_busy;
    logic       a_ld, b_ld, c_ld, o_ld;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_send_hex #(.WORDS(2), .ADDR_EN(1'b0), .UPPER(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_d && (sel == 2'd0)), .data(data_d[63:0]),
        .addr(addr_d), .crlf_in(crlf_d && (sel == 2'd0)), .tx_fifo_full(full_d),
        .send_char(a_ch), .send_en(a_en), .busy(a_bsy), .line_done(a_ld));

    uart_send_hex #(.WORDS(1), .ADDR_EN(1'b1), .UPPER(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_d && (sel == 2'd1)), .data(data_d[31:0]),
        .addr(addr_d), .crlf_in(crlf_d && (sel == 2'd1)), .tx_fifo_full(full_d),
        .send_char(b_ch), .send_en(b_en), .busy(b_bsy), .line_done(b_ld));

    uart_send_hex #(.WORDS(16), .ADDR_EN(1'b0), .UPPER(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_d && (sel == 2'd2)), .data(data_d),
        .addr(addr_d), .crlf_in(crlf_d && (sel == 2'd2)), .tx_fifo_full(full_d),
        .send_char(c_ch), .send_en(c_en), .busy(c_bsy), .line_done(c_ld));

    // Route the selected DUT to the common observation signals.
    always_comb begin
        o_ch = c_ch; o_en = c_en; o_busy = c_bsy; o_ld = c_ld;
        if (sel == 2'd0) begin
            o_ch = a_ch; o_en = a_en; o_busy = a_bsy; o_ld = a_ld;
        end else if (sel == 2'd1) begin
            o_ch = b_ch; o_en = b_en; o_busy = b_bsy; o_ld = b_ld;
        end
    end

    // Reference: the text a line should contain, built with string formatting.
    function automatic string model_line(input int s, input logic [511:0] d, input logic [31:0] a);
        int    nw = (s == 0) ? 2 : ((s == 1) ? 1 : 16);
        string r = "";
        if (s == 1) r = $sformatf("%08x: ", a);
        for (int k = 0; k < nw; k++) begin
            r = {r, $sformatf("%08x", d[32*k +: 32])};
            if (k < nw - 1) r = {r, " "};
        end
        if (s == 1) r = r.toupper();
        return {r, "\r\n"};
    endfunction

    function automatic void chk_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endfunction

    function automatic void chk_str(input string name, input string got, input string exp);
        int first = -1;
        int mx = (got.len() > exp.len()) ? got.len() : exp.len();
        n_vec++;
        if (got != exp) begin
            n_err++;
            for (int i = 0; i < mx; i++) begin
                if (first < 0 && got.getc(i) != exp.getc(i)) first = i;
            end
            $display("FAIL %s: len %0d want %0d, first diff at %0d: got 0x%02h want 0x%02h",
                     name, got.len(), exp.len(), first, got.getc(first), exp.getc(first));
        end
    endfunction

    // Drive one request into DUT s and collect what it writes until busy drops.
    task automatic run_line(input int s, input logic [511:0] d, input logic [31:0] a,
                            input bit do_start, input bit do_crlf, input int bp,
                            input int poke_at, input int rst_at, input bit b2b,
                            output string got, output int ncyc, output int ld_cnt,
                            output int ld_cyc, output int ld_bad, output int bp_viol,
                            output int hold_err);
        int         guard;
        logic [7:0] prev_ch;
        bit         prev_stall;
        got = ""; ncyc = 0; ld_cnt = 0; ld_cyc = 0; ld_bad = 0; bp_viol = 0; hold_err = 0;
        prev_stall = 1'b0; prev_ch = 8'h00;
        if (!b2b) @(negedge clk);
        sel = 2'(s); full_d = 1'b0;
        #1;
        guard = 0;
        while (o_busy && guard < 5000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 5000) got = "<idle timeout>";
        data_d = d; addr_d = a; start_d = do_start; crlf_d = do_crlf;
        @(negedge clk);
        start_d = 1'b0; crlf_d = 1'b0;
        while (o_busy && ncyc < 3000) begin
            full_d = (bp > 0) && (int'($urandom_range(0, 99)) < bp);
            if (poke_at > 0 && ncyc == poke_at) begin
                start_d = 1'b1; crlf_d = 1'b1; data_d = ~d; addr_d = ~a;
            end else begin
                start_d = 1'b0; crlf_d = 1'b0;
            end
            #1;
            ncyc++;
            if (prev_stall && o_ch != prev_ch) hold_err++;
            if (o_en) got = {got, $sformatf("%c", o_ch)};
            if (full_d && o_en) bp_viol++;
            if (o_ld) begin
                ld_cnt++;
                ld_cyc = ncyc;
                if (!o_en || o_ch != 8'h0A) ld_bad++;
            end
            prev_stall = !o_en;
            prev_ch = o_ch;
            if (rst_at > 0 && got.len() == rst_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                break;
            end
            @(negedge clk);
        end
        start_d = 1'b0; crlf_d = 1'b0; full_d = 1'b0;
    endtask

    task automatic check_line(input string name, input string got, input string exp,
                              input int bp, input int ncyc, input int ld_cnt, input int ld_cyc,
                              input int ld_bad, input int bp_viol, input int hold_err);
        chk_str({name, "_stream"}, got, exp);
        if (bp == 0) chk_int({name, "_cycles"}, ncyc, exp.len());
        chk_int({name, "_line_done_count"}, ld_cnt, 1);
        chk_int({name, "_line_done_last"}, ld_cyc, ncyc);
        chk_int({name, "_line_done_on_lf"}, ld_bad, 0);
        chk_int({name, "_en_while_full"}, bp_viol, 0);
        chk_int({name, "_char_hold"}, hold_err, 0);
    endtask

    typedef struct {
        int           s;
        logic [511:0] d;
        logic [31:0]  a;
        int           bp;
        string        exp;
    } vec_t;

    vec_t tbl[7];

    function automatic void set_vec(input int i, input int s, input logic [511:0] d,
                                    input logic [31:0] a, input int bp, input string exp);
        tbl[i].s = s; tbl[i].d = d; tbl[i].a = a; tbl[i].bp = bp; tbl[i].exp = exp;
    endfunction

    initial begin
        string        got, exp;
        int           ncyc, ld_cnt, ld_cyc, ld_bad, bp_viol, hold_err, extra;
        logic [511:0] dseq, drnd;
        logic [31:0]  arnd;
        int           s, bp;

        dseq = '0;
        for (int k = 0; k < 16; k++) dseq[32*k +: 32] = {8{4'(k)}};

        set_vec(0, 0, 512'h01234567_89ABCDEF, 32'h0, 0, "89abcdef 01234567\r\n");
        set_vec(1, 0, 512'h01234567_89ABCDEF, 32'h0, 50, "89abcdef 01234567\r\n");
        set_vec(2, 0, 512'hFFFFFFFF_00000000, 32'h0, 0, "00000000 ffffffff\r\n");
        set_vec(3, 1, 512'hDEADBEEF, 32'h00001000, 0, "00001000: DEADBEEF\r\n");
        set_vec(4, 1, 512'h0000F00D, 32'hCAFE00A5, 40, "CAFE00A5: 0000F00D\r\n");
        set_vec(5, 2, dseq, 32'h0, 0,
                {"00000000 11111111 22222222 33333333 44444444 55555555 66666666 77777777 ",
                 "88888888 99999999 aaaaaaaa bbbbbbbb cccccccc dddddddd eeeeeeee ffffffff\r\n"});
        set_vec(6, 2, dseq, 32'h0, 60, tbl[5].exp);

        // Reset values on all three configurations.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            chk_int($sformatf("rst%0d_busy", i), int'(o_busy), 0);
            chk_int($sformatf("rst%0d_send_en", i), int'(o_en), 0);
            chk_int($sformatf("rst%0d_line_done", i), int'(o_ld), 0);
            chk_int($sformatf("rst%0d_send_char", i), int'(o_ch), 32'h20);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 7; i++) begin
            run_line(tbl[i].s, tbl[i].d, tbl[i].a, 1'b1, 1'b0, tbl[i].bp, 0, 0, 1'b0,
                     got, ncyc, ld_cnt, ld_cyc, ld_bad, bp_viol, hold_err);
            check_line($sformatf("vec%0d", i), got, tbl[i].exp, tbl[i].bp, ncyc, ld_cnt,
                       ld_cyc, ld_bad, bp_viol, hold_err);
        end

        // Random lines against the string model.
        for (int r = 0; r < 9; r++) begin
            s = r % 3;
            for (int k = 0; k < 16; k++) drnd[32*k +: 32] = $urandom;
            arnd = $urandom;
            bp = (r < 3) ? 0 : ((r < 6) ? 30 : 70);
            exp = model_line(s, drnd, arnd);
            run_line(s, drnd, arnd, 1'b1, 1'b0, bp, 0, 0, 1'b0,
                     got, ncyc, ld_cnt, ld_cyc, ld_bad, bp_viol, hold_err);
            check_line($sformatf("rnd%0d", r), got, exp, bp, ncyc, ld_cnt, ld_cyc,
                       ld_bad, bp_viol, hold_err);
        end

        // Bare CR LF.
        run_line(0, '0, 32'h0, 1'b0, 1'b1, 0, 0, 0, 1'b0,
                 got, ncyc, ld_cnt, ld_cyc, ld_bad, bp_viol, hold_err);
        check_line("crlf", got, "\r\n", 0, ncyc, ld_cnt, ld_cyc, ld_bad, bp_viol, hold_err);

        // start and crlf_in together: data line only, no trailing CR LF afterwards.
        run_line(0, 512'h01234567_89ABCDEF, 32'h0, 1'b1, 1'b1, 0, 0, 0, 1'b0,
                 got, ncyc, ld_cnt, ld_cyc, ld_bad, bp_viol, hold_err);
        check_line("start_crlf", got, "89abcdef 01234567\r\n", 0, ncyc, ld_cnt, ld_cyc,
                   ld_bad, bp_viol, hold_err);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (o_busy) extra++;
        end
        chk_int("start_crlf_dropped", extra, 0);

        // Requests and new data mid-line leave the line untouched.
        run_line(0, 512'h01234567_89ABCDEF, 32'h0, 1'b1, 1'b0, 0, 5, 0, 1'b0,
                 got, ncyc, ld_cnt, ld_cyc, ld_bad, bp_viol, hold_err);
        check_line("poke", got, "89abcdef 01234567\r\n", 0, ncyc, ld_cnt, ld_cyc,
                   ld_bad, bp_viol, hold_err);

        // Back-to-back lines: next start taken in the single IDLE cycle.
        run_line(0, 512'h0BADF00D_12345678, 32'h0, 1'b1, 1'b0, 0, 0, 0, 1'b1,
                 got, ncyc, ld_cnt, ld_cyc, ld_bad, bp_viol, hold_err);
        check_line("b2b", got, "12345678 0badf00d\r\n", 0, ncyc, ld_cnt, ld_cyc,
                   ld_bad, bp_viol, hold_err);

        // Asynchronous reset after 5 characters, then a fresh line.
        run_line(0, 512'h01234567_89ABCDEF, 32'h0, 1'b1, 1'b0, 0, 0, 5, 1'b0,
                 got, ncyc, ld_cnt, ld_cyc, ld_bad, bp_viol, hold_err);
        chk_str("rstmid_prefix", got, "89abc");
        chk_int("rstmid_busy", int'(o_busy), 0);
        chk_int("rstmid_send_en", int'(o_en), 0);
        chk_int("rstmid_line_done", int'(o_ld), 0);
        chk_int("rstmid_send_char", int'(o_ch), 32'h20);
        @(negedge clk);
        rst_n = 1'b1;
        run_line(0, 512'hA5A5A5A5_3C3C3C3C, 32'h0, 1'b1, 1'b0, 0, 0, 0, 1'b0,
                 got, ncyc, ld_cnt, ld_cyc, ld_bad, bp_viol, hold_err);
        check_line("after_rst", got, "3c3c3c3c a5a5a5a5\r\n", 0, ncyc, ld_cnt, ld_cyc,
                   ld_bad, bp_viol, hold_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
